// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-side bundle for the hazard control unit.
//   master : the pipeline; drives stage information and halt_req, receives controls.
//   slave  : hazard_ctrl; receives stage information, drives stall/flush, status and counters.
// Signals:
//   ID_rs1/ID_rs2, ID_use_rs1/ID_use_rs2 : sources read by the instruction in ID
//   EX_rd, EX_reg_write, EX_reg_sel      : destination info of the instruction in EX
//   EX_jump                              : taken branch/jump resolved in EX
//   MEM_mem_req, MEM_mem_ack             : data-memory access handshake in MEM
//   halt_req                             : debug halt request (level)
//   stall_*, flush_*                     : per-stage hold / bubble controls
//   halted, mem_err                      : debug freeze state, sticky memory timeout
//   stall_cnt, flush_cnt                 : performance counters
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       ID_rs1;
    logic [4:0]       ID_rs2;
    logic             ID_use_rs1;
    logic             ID_use_rs2;
    logic [4:0]       EX_rd;
    logic             EX_reg_write;
    logic [2:0]       EX_reg_sel;
    logic             EX_jump;
    logic             MEM_mem_req;
    logic             MEM_mem_ack;
    logic             halt_req;
    logic             stall_if;
    logic             stall_id;
    logic             stall_ex;
    logic             stall_mem;
    logic             flush_id;
    logic             flush_ex;
    logic             flush_wb;
    logic             halted;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, EX_rd, EX_reg_write,
               EX_reg_sel, EX_jump, MEM_mem_req, MEM_mem_ack, halt_req,
        input  stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
               flush_wb, halted, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, EX_rd, EX_reg_write,
               EX_reg_sel, EX_jump, MEM_mem_req, MEM_mem_ack, halt_req,
        output stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
               flush_wb, halted, mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush control for the 5-stage RV32 pipeline.
// Resolves load-use hazards, EX-stage redirects and multi-cycle data-memory
// accesses, and adds a debug halt, a memory-wait timeout and two counters.
// Ports:
//   clk : core clock
//   rst : synchronous active-high reset
//   hz  : hazard_ctrl_if slave (stage info in, stall/flush/status/counters out)
// Stall/flush outputs are combinational from the state register and inputs.
module hazard_ctrl #(
    parameter int         MEM_TIMEOUT = 16,
    parameter int         CNT_W       = 32,
    parameter logic [2:0] LOAD_SEL    = 3'b001
) (
    input logic          clk,
    input logic          rst,
    hazard_ctrl_if.slave hz
);
    localparam int WCW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED} state_t;

    state_t           state_q, state_d;
    logic [WCW-1:0]   wait_q, wait_d;
    logic             err_q;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    logic load_use, mem_stall, timeout, freeze, jump_flush;

    assign load_use = hz.EX_reg_write && (hz.EX_reg_sel == LOAD_SEL) && (hz.EX_rd != 5'd0) &&
                      ((hz.ID_use_rs1 && (hz.ID_rs1 == hz.EX_rd)) ||
                       (hz.ID_use_rs2 && (hz.ID_rs2 == hz.EX_rd)));
    assign mem_stall = hz.MEM_mem_req && !hz.MEM_mem_ack;

    // Next state; wait_q counts stalled cycles of the current access, the
    // first one (taken while still in RUN) included.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        timeout = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d = MEM_WAIT;
                    wait_d  = WCW'(1);
                end else if (hz.halt_req) begin
                    state_d = HALTED;
                end
            end
            MEM_WAIT: begin
                if (!mem_stall) begin
                    state_d = RUN;
                end else if (wait_q == WCW'(MEM_TIMEOUT)) begin
                    // give up on the access: release the pipeline this cycle
                    timeout = 1'b1;
                    state_d = RUN;
                end else begin
                    wait_d = wait_q + WCW'(1);
                end
            end
            HALTED: begin
                if (!hz.halt_req) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    assign freeze     = (state_q == HALTED) || (mem_stall && !timeout);
    assign jump_flush = !rst && !freeze && hz.EX_jump;

    // Output priority: freeze > jump redirect > load-use bubble.
    always_comb begin
        hz.stall_if  = 1'b0;
        hz.stall_id  = 1'b0;
        hz.stall_ex  = 1'b0;
        hz.stall_mem = 1'b0;
        hz.flush_id  = 1'b0;
        hz.flush_ex  = 1'b0;
        hz.flush_wb  = 1'b0;
        if (!rst) begin
            if (freeze) begin
                hz.stall_if  = 1'b1;
                hz.stall_id  = 1'b1;
                hz.stall_ex  = 1'b1;
                hz.stall_mem = 1'b1;
                hz.flush_wb  = 1'b1;
            end else if (hz.EX_jump) begin
                // a concurrent load-use belongs to the wrong path
                hz.flush_id = 1'b1;
                hz.flush_ex = 1'b1;
            end else if (load_use) begin
                hz.stall_if = 1'b1;
                hz.stall_id = 1'b1;
                hz.flush_ex = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wait_q      <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (timeout)     err_q       <= 1'b1;
            if (hz.stall_if) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (jump_flush)  flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign hz.halted    = (state_q == HALTED);
    assign hz.mem_err   = err_q;
    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a stimulus process drives one input set
// per cycle and pushes the reference model's expected response; a negedge
// monitor pops and compares against the DUT.
module tb_hazard_ctrl;
    localparam int         TO    = 4;
    localparam int         CW    = 8;
    localparam logic [2:0] LSEL  = 3'b001;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CW)) hz ();

    hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW), .LOAD_SEL(LSEL)) dut (
        .clk(clk), .rst(rst), .hz(hz)
    );

    typedef struct {
        logic       rst;
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, wr, jump, req, ack, halt;
        logic [2:0] sel;
    } stim_t;

    typedef struct {
        logic [8:0]    ctl;   // stall if/id/ex/mem, flush id/ex/wb, halted, mem_err
        logic [CW-1:0] sc, fc;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // reference model state
    int m_wait;   // stalled cycles of the pending access, 0 = no access pending
    bit m_halt, m_err;
    int m_sc, m_fc;

    task automatic model(input stim_t s);
        bit lu, ms, to, frz;
        logic [6:0] fl;
        exp_t e;
        lu = s.wr && s.sel == LSEL && s.rd != 0 &&
             ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
        ms  = s.req && !s.ack;
        to  = m_wait > 0 && ms && m_wait == TO;
        frz = m_halt || (ms && !to);
        if (s.rst)       fl = 7'b0000000;
        else if (frz)    fl = 7'b1111001;
        else if (s.jump) fl = 7'b0000110;
        else if (lu)     fl = 7'b1100010;
        else             fl = 7'b0000000;
        e.ctl = {fl, m_halt, m_err};
        e.sc  = CW'(m_sc);
        e.fc  = CW'(m_fc);
        exp_q.push_back(e);
        if (s.rst) begin
            m_wait = 0; m_halt = 0; m_err = 0; m_sc = 0; m_fc = 0;
        end else begin
            m_sc = (m_sc + int'(fl[6])) % (1 << CW);
            if (!frz && s.jump) m_fc = (m_fc + 1) % (1 << CW);
            if (m_halt) begin
                m_halt = s.halt;
            end else if (m_wait > 0) begin
                if (!ms)     m_wait = 0;
                else if (to) begin m_wait = 0; m_err = 1; end
                else         m_wait = m_wait + 1;
            end else if (ms) begin
                m_wait = 1;
            end else if (s.halt) begin
                m_halt = 1;
            end
        end
    endtask

    task automatic drive(input stim_t s);
        rst             = s.rst;
        hz.ID_rs1       = s.rs1;
        hz.ID_rs2       = s.rs2;
        hz.ID_use_rs1   = s.u1;
        hz.ID_use_rs2   = s.u2;
        hz.EX_rd        = s.rd;
        hz.EX_reg_write = s.wr;
        hz.EX_reg_sel   = s.sel;
        hz.EX_jump      = s.jump;
        hz.MEM_mem_req  = s.req;
        hz.MEM_mem_ack  = s.ack;
        hz.halt_req     = s.halt;
    endtask

    // one checked cycle: apply inputs, record expectation, advance past the edge
    task automatic step(input stim_t s);
        drive(s);
        model(s);
        @(posedge clk);
        #1;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.rst = 0; s.rs1 = 0; s.rs2 = 0; s.rd = 0;
        s.u1 = 0; s.u2 = 0; s.wr = 0; s.jump = 0;
        s.req = 0; s.ack = 0; s.halt = 0; s.sel = 3'b000;
        return s;
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [8:0] act;
            e   = exp_q.pop_front();
            act = {hz.stall_if, hz.stall_id, hz.stall_ex, hz.stall_mem, hz.flush_id,
                   hz.flush_ex, hz.flush_wb, hz.halted, hz.mem_err};
            checks++;
            if (act !== e.ctl) begin
                errors++;
                $display("FAIL ctl t=%0t got %b want %b", $time, act, e.ctl);
            end
            checks++;
            if (hz.stall_cnt !== e.sc) begin
                errors++;
                $display("FAIL stall_cnt t=%0t got %0d want %0d", $time, hz.stall_cnt, e.sc);
            end
            checks++;
            if (hz.flush_cnt !== e.fc) begin
                errors++;
                $display("FAIL flush_cnt t=%0t got %0d want %0d", $time, hz.flush_cnt, e.fc);
            end
        end
    end

    initial begin
        stim_t s;
        bit pend;
        bit hlvl;
        m_wait = 0; m_halt = 0; m_err = 0; m_sc = 0; m_fc = 0;
        // unchecked first cycle: registers are unknown until the first reset edge
        s = idle(); s.rst = 1;
        drive(s);
        @(posedge clk);
        #1;
        // reset state
        step(s);
        s.rst = 0;
        step(s);

        // load-use: lw x5 in EX, add x6,x5,x7 in ID; then the load moves on
        s = idle(); s.wr = 1; s.sel = LSEL; s.rd = 5; s.rs1 = 5; s.rs2 = 7; s.u1 = 1; s.u2 = 1;
        step(s);
        step(idle());
        // same with EX_rd = x0: no hazard
        s.rd = 0; s.rs1 = 0;
        step(s);
        // jump together with load-use
        s = idle(); s.wr = 1; s.sel = LSEL; s.rd = 9; s.rs2 = 9; s.u2 = 1; s.jump = 1;
        step(s);
        step(idle());

        // memory access acked after 3 stalled cycles
        s = idle(); s.req = 1;
        repeat (3) step(s);
        s.ack = 1;
        step(s);
        step(idle());

        // memory timeout, then mem_err sticks
        s = idle(); s.req = 1;
        repeat (TO + 1) step(s);
        step(idle());
        step(idle());

        // halt pulse of 5 cycles
        s = idle(); s.halt = 1;
        repeat (5) step(s);
        repeat (3) step(idle());

        // halt during a memory wait is taken only after the ack
        s = idle(); s.req = 1; s.halt = 1;
        repeat (2) step(s);
        s.ack = 1;
        step(s);
        s = idle(); s.halt = 1;
        repeat (2) step(s);
        step(idle());
        step(idle());

        // reset in the middle of a memory wait
        s = idle(); s.req = 1;
        repeat (2) step(s);
        s.rst = 1;
        step(s);
        step(idle());
        step(idle());

        // randomized traffic with a req-until-ack memory protocol
        pend = 0;
        hlvl = 0;
        for (int i = 0; i < 3000; i++) begin
            s = idle();
            s.rst  = ($urandom_range(0, 199) == 0);
            s.rs1  = 5'($urandom_range(0, 3));
            s.rs2  = 5'($urandom_range(0, 3));
            s.rd   = 5'($urandom_range(0, 3));
            s.u1   = 1'($urandom);
            s.u2   = 1'($urandom);
            s.wr   = ($urandom_range(0, 3) != 0);
            s.sel  = ($urandom_range(0, 1) == 0) ? LSEL : 3'($urandom);
            s.jump = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0) hlvl = !hlvl;
            s.halt = hlvl;
            s.req  = pend ? 1'b1 : ($urandom_range(0, 5) == 0);
            s.ack  = s.req && ($urandom_range(0, 3) == 0);
            pend   = s.req && !s.ack;
            step(s);
        end

        // drain the scoreboard with a bound
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control unit for the 5-stage RV32 core; it handles the hazards that EX-stage operand bypassing cannot resolve.
- Detects load-use hazards, taken-branch/jump redirects and multi-cycle data-memory accesses.
- Drives per-stage stall (hold) and flush (bubble) signals into the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Adds a debug halt FSM, a memory-wait timeout and two performance counters.

Parameters:
- MEM_TIMEOUT, 16: max consecutive cycles in MEM_WAIT before an error is raised (>=1).
- CNT_W, 32: width of the performance counters.
- LOAD_SEL, 3'b001: reg_sel encoding that marks a load (write-back data comes from memory).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- ID_rs1, ID_rs2  in  5 each  source registers of the instruction in ID
- ID_use_rs1, ID_use_rs2  in  1 each  the instruction in ID actually reads that source
- EX_rd  in  5  destination of the instruction in EX
- EX_reg_write  in  1  instruction in EX writes the RF
- EX_reg_sel  in  3  write-back source select of the instruction in EX
- EX_jump  in  1  taken branch or jump resolved in EX
- MEM_mem_req  in  1  instruction in MEM accesses data memory
- MEM_mem_ack  in  1  data memory completes the access this cycle
- halt_req  in  1  debug halt request (level)
- stall_if, stall_id, stall_ex, stall_mem  out  1 each  hold the PC / that stage's pipeline register
- flush_id, flush_ex, flush_wb  out  1 each  load a bubble into IF/ID, ID/EX, MEM/WB
- halted  out  1  core frozen by debug
- mem_err  out  1  sticky memory-timeout flag
- stall_cnt  out  CNT_W  cycles with stall_if=1
- flush_cnt  out  CNT_W  cycles with a jump flush

Behaviour:
- All stall/flush outputs are combinational from the state register and current inputs.
- States are RUN, MEM_WAIT and HALTED. Reset places the FSM in RUN and clears mem_err, halted, both counters and the wait counter. While rst=1, all stall/flush outputs are 0.
- Definitions:
  - load_use = EX_reg_write & EX_reg_sel==LOAD_SEL & EX_rd!=0 & ((ID_use_rs1 & ID_rs1==EX_rd) | (ID_use_rs2 & ID_rs2==EX_rd)).
  - mem_stall = MEM_mem_req & ~MEM_mem_ack.
- Output priority, highest first:
  - (1) state HALTED, or mem_stall in any state: stall_if=stall_id=stall_ex=stall_mem=1, flush_wb=1, all other flushes 0. Jump and load_use are ignored this cycle and are re-evaluated once the freeze ends.
  - (2) EX_jump: flush_id=flush_ex=1, no stalls. A load_use in the same cycle is discarded because the ID instruction is wrong-path.
  - (3) load_use: stall_if=stall_id=1, flush_ex=1 for exactly one cycle. The next cycle the load is in MEM, so the condition clears by itself.
  - (4) otherwise all outputs are 0.
- RUN:
  - mem_stall goes to MEM_WAIT and loads wait_cnt=1.
  - Else halt_req goes to HALTED. Normal control applies in that cycle, and the freeze starts the next cycle.
- MEM_WAIT:
  - MEM_mem_ack=1 goes to RUN; that ack cycle is unstalled.
  - Else wait_cnt increments.
  - When wait_cnt==MEM_TIMEOUT with no ack, set mem_err=1 and go to RUN. Stalls drop that cycle and the access is abandoned.
  - halt_req is ignored in MEM_WAIT; it is taken in RUN afterwards.
- HALTED:
  - halted=1 and the full freeze applies.
  - halt_req=0 goes to RUN, and halted falls with the state.
- mem_err stays set until rst.
- stall_cnt increments in every cycle where stall_if=1. flush_cnt increments in every cycle where case (2) applies. Both wrap modulo 2^CNT_W.
- Reset mid-wait or mid-halt returns to RUN on the next edge regardless of inputs.

Test Plan:
- lw x5 in EX with ID add x6,x5,x7 (use_rs1=1): one cycle of stall_if=stall_id=flush_ex=1, then all 0; stall_cnt=1. The same case with EX_rd=0 gives no stall.
- EX_jump=1 together with load_use=1: flush_id=flush_ex=1, stall_if=0; flush_cnt increments to 1 and stall_cnt stays 0.
- MEM_mem_req=1 with ack after 3 cycles: 3 cycles of full freeze plus flush_wb=1, the ack cycle clean; state returns to RUN and stall_cnt=3.
- MEM_TIMEOUT=4, req held with no ack: mem_err rises at the 4th wait cycle and stalls drop; mem_err remains 1 until rst.
- halt_req pulse for 5 cycles from RUN: halted=1 from the cycle after assertion until the cycle after deassertion, with full freeze throughout. halt_req during MEM_WAIT is honoured only after ack.
- rst asserted while in MEM_WAIT: the next cycle is RUN with counters, mem_err and halted at 0 and all outputs 0.
